jk_excitation_gen: RTL and testbench

Drives the J/K (or S/R) inputs of an external WIDTH-bit register bank built from JK flip-flops so that the bank reaches a requested target word. It accepts targets over a valid/ready handshake, computes per-bit excitation from the bank's current Q, drives the bank for one cycle, and checks the bank's Q against the target. It reports done/error and keeps running counts. It is the stimulus side of the team's flip-flop conversion blocks: it produces what those blocks consume.

---
 rtl/jk_excitation_gen_pkg.sv | 19 +
 rtl/jk_excitation_gen_ff_excite_bit.sv | 33 +++
 rtl/jk_excitation_gen.sv | 102 ++++++++++
 tb/tb_jk_excitation_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/jk_excitation_gen_pkg.sv
// Shared types and constants for the JK/SR excitation generator.
// The excitation pair is packed as {j, k}.
package jk_excitation_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  localparam int APPLY_CNT_W = 16;
  localparam int ERR_CNT_W   = 8;

endpackage

// File: rtl/jk_excitation_gen_ff_excite_bit.sv
// Per-bit excitation encoder: picks the {j,k} pair that moves one JK
// flip-flop from its current value to the requested next value.
module ff_excite_bit
  import jk_excitation_gen_pkg::*;
(
  input  logic cur,
  input  logic nxt,
  input  logic sr_mode,
  input  logic toggle_en,
  output logic j,
  output logic k
);

  logic [1:0] exc;

  // SR mode must never see S=R=1, so toggling is only offered in JK mode.
  always_comb begin
    exc = HOLD;
    if (cur != nxt) begin
      if (!sr_mode && toggle_en) begin
        exc = TOGGLE;
      end else if (nxt) begin
        exc = SET;
      end else begin
        exc = RESET;
      end
    end
  end

  assign j = exc[1];
  assign k = exc[0];

endmodule

// File: rtl/jk_excitation_gen.sv
// Drives an external JK/SR register bank toward an accepted target word,
// then checks the bank's Q against that target and keeps running counts.
module jk_excitation_gen
  import jk_excitation_gen_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit TOGGLE_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tgt_valid,
  output logic                   tgt_ready,
  input  logic [WIDTH-1:0]       tgt_data,
  input  logic                   sr_mode,
  input  logic [WIDTH-1:0]       q_fb,
  output logic [WIDTH-1:0]       j_out,
  output logic [WIDTH-1:0]       k_out,
  output logic                   done,
  output logic                   err,
  output logic [APPLY_CNT_W-1:0] apply_cnt,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;
  logic             accept;
  logic             mismatch;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_excite_bit u_bit (
      .cur       (q_fb[i]),
      .nxt       (tgt_data[i]),
      .sr_mode   (sr_mode),
      .toggle_en (TOGGLE_EN),
      .j         (exc_j[i]),
      .k         (exc_k[i])
    );
  end

  assign tgt_ready = (state == IDLE);
  assign accept    = tgt_valid && tgt_ready;
  assign mismatch  = (q_fb != tgt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = DRIVE;
      DRIVE:   next_state = CHECK;
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Excitation is captured at accept so the bank sees it for exactly the DRIVE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_out     <= '0;
      k_out     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      apply_cnt <= '0;
      err_cnt   <= '0;
      tgt_q     <= '0;
    end else begin
      j_out <= '0;
      k_out <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_q <= tgt_data;
            j_out <= exc_j;
            k_out <= exc_k;
          end
        end
        CHECK: begin
          done <= 1'b1;
          err  <= mismatch;
          if (apply_cnt != '1) begin
            apply_cnt <= apply_cnt + 1'b1;
          end
          if (mismatch && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_gen.sv
// Self-checking bench: a JK flip-flop bank model with optional stuck-at-0 bits
// closes the loop around the generator; vectors, corner sequences and random targets.
module tb_jk_excitation_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [7:0]  tgt_data;
  logic        sr_mode;
  logic [7:0]  q_fb;
  logic [7:0]  j_out;
  logic [7:0]  k_out;
  logic        done;
  logic        err;
  logic [15:0] apply_cnt;
  logic [7:0]  err_cnt;

  logic [7:0]  bank;
  logic        bank_load;
  logic [7:0]  bank_load_val;
  logic [7:0]  stuck0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          accepts  = 0;
  logic [15:0] exp_apply;
  logic [7:0]  exp_err;

  typedef struct {
    string      name;
    logic [7:0] start;
    logic [7:0] stk;
    logic       sr;
    logic [7:0] tgt;
    logic [7:0] ej;
    logic [7:0] ek;
    logic       eerr;
  } vec_t;

  vec_t vecs[6];

  jk_excitation_gen #(.WIDTH(8), .TOGGLE_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .sr_mode   (sr_mode),
    .q_fb      (q_fb),
    .j_out     (j_out),
    .k_out     (k_out),
    .done      (done),
    .err       (err),
    .apply_cnt (apply_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // External bank of JK flip-flops: Q+ = J&~Q | ~K&Q.
  always @(posedge clk) begin
    if (bank_load) bank <= bank_load_val;
    else           bank <= (j_out & ~bank) | (~k_out & bank);
  end

  assign q_fb = bank & ~stuck0;

  always @(posedge clk) begin
    if (tgt_valid && tgt_ready) accepts <= accepts + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] tgt, input logic sr);
    tgt_data  = tgt;
    sr_mode   = sr;
    tgt_valid = 1'b1;
  endtask

  task automatic loadBank(input logic [7:0] start, input logic [7:0] stk);
    bank_load     = 1'b1;
    bank_load_val = start;
    stuck0        = stk;
    @(negedge clk);
    bank_load     = 1'b0;
  endtask

  // One full transaction, entered and left on a negedge in IDLE.
  task automatic runTxn(input string name, input logic [7:0] start, input logic [7:0] stk,
                        input logic sr, input logic [7:0] tgt, input logic [7:0] ej,
                        input logic [7:0] ek, input logic eerr);
    loadBank(start, stk);
    applyStimulus(tgt, sr);
    checkOutput({name, " ready_idle"}, 32'(tgt_ready), 32'd1);
    @(negedge clk);
    tgt_valid = 1'b0;
    checkOutput({name, " j_drive"}, 32'(j_out), 32'(ej));
    checkOutput({name, " k_drive"}, 32'(k_out), 32'(ek));
    checkOutput({name, " ready_drive"}, 32'(tgt_ready), 32'd0);
    if (sr) checkOutput({name, " no_s_and_r"}, 32'(j_out & k_out), 32'd0);
    @(negedge clk);
    checkOutput({name, " ready_check"}, 32'(tgt_ready), 32'd0);
    checkOutput({name, " jk_idle_check"}, 32'({j_out, k_out}), 32'd0);
    @(negedge clk);
    if (exp_apply != 16'hFFFF) exp_apply = exp_apply + 16'd1;
    if (eerr && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    checkOutput({name, " done"}, 32'(done), 32'd1);
    checkOutput({name, " err"}, 32'(err), 32'(eerr));
    checkOutput({name, " q_fb"}, 32'(q_fb), 32'(tgt & ~stk));
    checkOutput({name, " apply_cnt"}, 32'(apply_cnt), 32'(exp_apply));
    checkOutput({name, " err_cnt"}, 32'(err_cnt), 32'(exp_err));
    checkOutput({name, " ready_done"}, 32'(tgt_ready), 32'd1);
    @(negedge clk);
    checkOutput({name, " done_pulse"}, 32'(done), 32'd0);
    checkOutput({name, " err_held"}, 32'(err), 32'(eerr));
  endtask

  initial begin
    vecs[0] = '{"jk_toggle_a5", 8'h00, 8'h00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{"sr_a5_to_3c",  8'hA5, 8'h00, 1'b1, 8'h3C, 8'h18, 8'h81, 1'b0};
    vecs[2] = '{"same_3c",      8'h3C, 8'h00, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{"stuck_bit0",   8'h00, 8'h01, 1'b0, 8'h01, 8'h01, 8'h01, 1'b1};
    vecs[4] = '{"sr_clear_all", 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0};
    vecs[5] = '{"jk_nibble",    8'h0F, 8'h00, 1'b0, 8'hF0, 8'hFF, 8'hFF, 1'b0};

    rst = 1'b1; tgt_valid = 1'b0; tgt_data = '0; sr_mode = 1'b0;
    bank_load = 1'b1; bank_load_val = 8'h00; stuck0 = 8'h00;
    exp_apply = '0; exp_err = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; bank_load = 1'b0;

    checkOutput("reset tgt_ready", 32'(tgt_ready), 32'd1);
    checkOutput("reset j_out",     32'(j_out), 32'd0);
    checkOutput("reset k_out",     32'(k_out), 32'd0);
    checkOutput("reset done",      32'(done), 32'd0);
    checkOutput("reset err",       32'(err), 32'd0);
    checkOutput("reset apply_cnt", 32'(apply_cnt), 32'd0);
    checkOutput("reset err_cnt",   32'(err_cnt), 32'd0);

    for (int v = 0; v < 6; v++) begin
      runTxn(vecs[v].name, vecs[v].start, vecs[v].stk, vecs[v].sr,
             vecs[v].tgt, vecs[v].ej, vecs[v].ek, vecs[v].eerr);
    end

    // Back-to-back offers: accepts land every third cycle.
    loadBank(8'h00, 8'h00);
    accepts = 0;
    applyStimulus(8'h55, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("b2b ready[%0d]", i), 32'(tgt_ready), 32'((i % 3) == 0));
      checkOutput($sformatf("b2b done[%0d]", i), 32'(done), 32'(i > 0 && (i % 3) == 0));
      @(negedge clk);
    end
    tgt_valid = 1'b0;
    checkOutput("b2b accepts", 32'(accepts), 32'd3);
    checkOutput("b2b last_done", 32'(done), 32'd1);
    exp_apply = exp_apply + 16'd3;
    checkOutput("b2b apply_cnt", 32'(apply_cnt), 32'(exp_apply));
    @(negedge clk);

    // Reset while DRIVE is in progress drops the transaction.
    loadBank(8'h00, 8'h00);
    applyStimulus(8'hFF, 1'b0);
    @(negedge clk);
    tgt_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_apply = '0; exp_err = '0;
    checkOutput("rst_drive j_out", 32'(j_out), 32'd0);
    checkOutput("rst_drive k_out", 32'(k_out), 32'd0);
    checkOutput("rst_drive ready", 32'(tgt_ready), 32'd1);
    checkOutput("rst_drive apply_cnt", 32'(apply_cnt), 32'd0);
    checkOutput("rst_drive err_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_drive no_done[%0d]", i), 32'(done), 32'd0);
      @(negedge clk);
    end

    // Random targets checked against set/reset/toggle rules computed from the bit differences.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] start, stk, tgt, diff, ej, ek;
      logic       sr;
      start = 8'($urandom);
      stk   = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      start = start & ~stk;
      tgt   = ($urandom_range(0, 7) == 0) ? start : 8'($urandom);
      sr    = 1'($urandom_range(0, 1));
      diff  = start ^ tgt;
      if (sr) begin
        ej = diff & tgt;
        ek = diff & ~tgt;
      end else begin
        ej = diff;
        ek = diff;
      end
      runTxn($sformatf("rand%0d", n), start, stk, sr, tgt, ej, ek, |(tgt & stk));
    end

    // Saturation of both counters.
    force dut.apply_cnt = 16'hFFFF;
    force dut.err_cnt   = 8'hFF;
    @(negedge clk);
    release dut.apply_cnt;
    release dut.err_cnt;
    exp_apply = 16'hFFFF;
    exp_err   = 8'hFF;
    checkOutput("sat preload apply_cnt", 32'(apply_cnt), 32'hFFFF);
    runTxn("sat", 8'h00, 8'h80, 1'b0, 8'h80, 8'h80, 8'h80, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
